exec_datapath_p: RTL and testbench

- Parametrised execute-stage datapath for the ARM32 pipeline core.
- Takes register-file read data plus NUM_FWD forwarding buses, selects operands, and applies the barrel shifter and ALU.
- Maintains the NZCV status register and registers the result behind a valid/ready handshake.
- Adds flush and an optional iterative multiplier.

---
 rtl/exec_datapath_p.sv | 214 +++++++++++++++++++++
 tb/tb_exec_datapath_p.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_datapath_p.sv
// Execute stage: operand select, barrel shifter, ALU, NZCV flags and a registered result.
// Latency: 2 cycles from offer to out_valid (DATA_W+1 for MUL when EXEC_MUL_EN is defined).
// Backpressure: result held in HOLD until out_ready; a new op is taken in the same cycle as the drain.
module exec_datapath_p #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 2)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         rf_a,
    input  logic [DATA_W-1:0]         rf_b,
    input  logic [DATA_W-1:0]         rf_s,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [SEL_W-1:0]          sel_a,
    input  logic [SEL_W-1:0]          sel_b,
    input  logic [SEL_W-1:0]          sel_s,
    input  logic [DATA_W-1:0]         imm,
    input  logic                      use_imm,
    input  logic [1:0]                shift_op,
    input  logic [7:0]                shift_imm,
    input  logic                      shift_by_reg,
    input  logic [3:0]                alu_op,
    input  logic                      set_flags,
    input  logic                      post_index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         result,
    output logic [DATA_W-1:0]         addr_out,
    output logic [3:0]                flags,
    output logic                      busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [31:0] WL = 32'(DATA_W);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, HOLD} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] a_q, b_q, result_q, addr_q;
    logic [7:0]        amt_q;
    logic [1:0]        shift_op_q;
    logic [3:0]        alu_op_q, flags_q;
    logic              use_imm_q, set_flags_q, post_index_q;

    function automatic logic [DATA_W-1:0] pick(input logic [SEL_W-1:0] sel,
                                               input logic [DATA_W-1:0] rf,
                                               input logic [NUM_FWD*DATA_W-1:0] fwd);
        logic [DATA_W-1:0] v;
        v = '0;
        if (sel == '0) v = rf;
        for (int k = 0; k < NUM_FWD; k++)
            if (sel == SEL_W'(k + 1)) v = fwd[k*DATA_W +: DATA_W];
        return v;
    endfunction

    logic [DATA_W-1:0] op_a, op_b, op_s;
    logic              unused_s;
    assign op_a     = pick(sel_a, rf_a, fwd_data);
    assign op_b     = pick(sel_b, rf_b, fwd_data);
    assign op_s     = pick(sel_s, rf_s, fwd_data);
    assign unused_s = ^op_s;

    logic accept;
    assign in_ready = !flush && (state_q == IDLE || (state_q == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    // Shifter on the registered B operand; carry-in is the live C flag.
    logic [DATA_W-1:0] b_sh, rot;
    logic              sh_c;
    logic [DATA_W:0]   sh_l, sh_r, sh_a;
    logic [31:0]       amt32, asr_n;
    logic [CNT_W-1:0]  rot_n;
    always_comb begin
        b_sh  = b_q;
        sh_c  = flags_q[1];
        amt32 = 32'(amt_q);
        asr_n = (amt32 > WL) ? WL : amt32;
        rot_n = CNT_W'(amt_q);
        sh_l  = {1'b0, b_q} << amt_q;
        sh_r  = {b_q, 1'b0} >> amt_q;
        sh_a  = $signed({b_q, 1'b0}) >>> asr_n;
        rot   = DATA_W'({b_q, b_q} >> rot_n);
        if (!use_imm_q && amt_q != 8'd0) begin
            case (shift_op_q)
                2'd0: {sh_c, b_sh} = (amt32 <= WL) ? sh_l : '0;
                2'd1: {b_sh, sh_c} = (amt32 <= WL) ? sh_r : '0;
                2'd2: {b_sh, sh_c} = sh_a;
                default: begin
                    b_sh = rot;
                    sh_c = rot[DATA_W-1];
                end
            endcase
        end
    end

    logic [DATA_W-1:0] bx, alu_res;
    logic [DATA_W:0]   sum;
    logic              cin, alu_c, alu_v, is_sub;
    logic [3:0]        alu_flags;
    always_comb begin
        is_sub  = (alu_op_q == 4'd2) || (alu_op_q == 4'd3);
        cin     = (alu_op_q == 4'd1 || alu_op_q == 4'd3) ? flags_q[1] : is_sub;
        bx      = is_sub ? ~b_sh : b_sh;
        sum     = {1'b0, a_q} + {1'b0, bx} + {{DATA_W{1'b0}}, cin};
        alu_res = b_sh;
        alu_c   = sh_c;
        alu_v   = flags_q[0];
        case (alu_op_q)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[DATA_W-1] == bx[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd4:    alu_res = a_q & b_sh;
            4'd5:    alu_res = a_q | b_sh;
            4'd6:    alu_res = a_q ^ b_sh;
            4'd8:    alu_res = ~b_sh;
            4'd9:    alu_res = '0;
            default: alu_res = b_sh;
        endcase
        alu_flags = {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
    end

`ifdef EXEC_MUL_EN
    logic [DATA_W-1:0] acc_q, mul_part, mul_acc;
    logic [CNT_W-1:0]  cnt_q;
    logic              mul_last;
    assign mul_part = b_sh[cnt_q] ? (a_q << cnt_q) : '0;
    assign mul_acc  = acc_q + mul_part;
    assign mul_last = (cnt_q == CNT_W'(DATA_W - 1));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = HOLD;
`ifdef EXEC_MUL_EN
            MUL:  if (mul_last) state_d = HOLD;
`endif
            HOLD: if (out_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
`ifdef EXEC_MUL_EN
        if (accept && alu_op == 4'd9) state_d = MUL;
`endif
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            amt_q        <= '0;
            shift_op_q   <= '0;
            alu_op_q     <= '0;
            use_imm_q    <= 1'b0;
            set_flags_q  <= 1'b0;
            post_index_q <= 1'b0;
            result_q     <= '0;
            addr_q       <= '0;
            flags_q      <= '0;
`ifdef EXEC_MUL_EN
            acc_q        <= '0;
            cnt_q        <= '0;
`endif
        end else begin
            if (accept) begin
                a_q          <= op_a;
                b_q          <= use_imm ? imm : op_b;
                amt_q        <= shift_by_reg ? op_s[7:0] : shift_imm;
                shift_op_q   <= shift_op;
                alu_op_q     <= alu_op;
                use_imm_q    <= use_imm;
                set_flags_q  <= set_flags;
                post_index_q <= post_index;
`ifdef EXEC_MUL_EN
                acc_q        <= '0;
                cnt_q        <= '0;
`endif
            end
            if (state_q == EXEC && !flush) begin
                result_q <= alu_res;
                addr_q   <= post_index_q ? a_q : alu_res;
                if (set_flags_q && alu_op_q != 4'd9) flags_q <= alu_flags;
            end
`ifdef EXEC_MUL_EN
            if (state_q == MUL && !flush) begin
                acc_q <= mul_acc;
                cnt_q <= cnt_q + 1'b1;
                if (mul_last) begin
                    result_q <= mul_acc;
                    addr_q   <= post_index_q ? a_q : mul_acc;
                    if (set_flags_q) flags_q[3:2] <= {mul_acc[DATA_W-1], mul_acc == '0};
                end
            end
`endif
        end
    end

    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign addr_out  = addr_q;
    assign flags     = flags_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_exec_datapath_p.sv
// Self-checking bench for exec_datapath_p: expected results are queued at issue and compared on out_valid.
module tb_exec_datapath_p;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, use_imm, shift_by_reg, set_flags, post_index;
    logic        out_valid, out_ready, busy;
    logic [31:0] rf_a, rf_b, rf_s, imm, result, addr_out;
    logic [63:0] fwd_data;
    logic [1:0]  sel_a, sel_b, sel_s, shift_op;
    logic [7:0]  shift_imm;
    logic [3:0]  alu_op, flags;

    exec_datapath_p #(.DATA_W(32), .NUM_FWD(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rf_a(rf_a), .rf_b(rf_b), .rf_s(rf_s), .fwd_data(fwd_data),
        .sel_a(sel_a), .sel_b(sel_b), .sel_s(sel_s), .imm(imm), .use_imm(use_imm),
        .shift_op(shift_op), .shift_imm(shift_imm), .shift_by_reg(shift_by_reg),
        .alu_op(alu_op), .set_flags(set_flags), .post_index(post_index),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .addr_out(addr_out),
        .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] addr;
        logic [3:0]  fl;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] mflags;
    int         n_pass = 0;
    int         n_chk  = 0;
    int         lat;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush = 0; in_valid = 0; out_ready = 1;
        rf_a = 0; rf_b = 0; rf_s = 0; imm = 0; fwd_data = 0;
        sel_a = 0; sel_b = 0; sel_s = 0; use_imm = 0;
        shift_op = 0; shift_imm = 0; shift_by_reg = 0;
        alu_op = 4'd7; set_flags = 0; post_index = 0;
    endtask

    task automatic run_op(output int l);
        in_valid = 1;
        tick();
        in_valid = 0;
        l = 1;
        while (out_valid !== 1'b1 && l < 100) begin
            tick();
            l++;
        end
    endtask

    // Independent reference: LSL-by-immediate shifter plus the ALU ops used in random traffic.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input int n, input logic [3:0] fl);
        logic [31:0] bs, r;
        logic [63:0] s;
        logic        c, v;
        bs = b << n;
        c  = (n == 0) ? fl[1] : b[32-n];
        v  = fl[0];
        case (op)
            4'd0: begin
                s = {32'b0, a} + {32'b0, bs};
                r = s[31:0]; c = s[32];
                v = (a[31] == bs[31]) && (r[31] != a[31]);
            end
            4'd2: begin
                r = a - bs; c = (a >= bs);
                v = (a[31] != bs[31]) && (r[31] != a[31]);
            end
            4'd4:    r = a & bs;
            4'd5:    r = a | bs;
            4'd6:    r = a ^ bs;
            4'd8:    r = ~bs;
            default: r = bs;
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_chk++; if (result !== 32'd0) $display("FAIL reset_result got %h exp 0", result); else n_pass++;
        n_chk++; if (addr_out !== 32'd0) $display("FAIL reset_addr got %h exp 0", addr_out); else n_pass++;
        n_chk++; if (flags !== 4'd0) $display("FAIL reset_flags got %b exp 0000", flags); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        rst_n = 1;
        mflags = 4'd0;
        tick();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_add;
        idle_inputs();
        rf_a = 32'h7FFF_FFFF; rf_b = 32'd1; alu_op = 4'd0; set_flags = 1;
        mflags = 4'b1001;
        sb.push_back('{res: 32'h8000_0000, addr: 32'h8000_0000, fl: mflags});
        run_op(lat);
        e = sb.pop_front();
        n_chk++; if (lat != 2) $display("FAIL add_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (result !== e.res) $display("FAIL add_result got %h exp %h", result, e.res); else n_pass++;
        n_chk++; if (addr_out !== e.addr) $display("FAIL add_addr got %h exp %h", addr_out, e.addr); else n_pass++;
        n_chk++; if (flags !== e.fl) $display("FAIL add_flags got %b exp %b", flags, e.fl); else n_pass++;
        tick();
    endtask

    task automatic test_fwd_sub;
        idle_inputs();
        rf_a = 32'h99; fwd_data = {32'h0000_1000, 32'd5};
        sel_a = 2'd1; sel_b = 2'd3; alu_op = 4'd2; set_flags = 1;
        mflags = 4'b0010;
        sb.push_back('{res: 32'd5, addr: 32'd5, fl: mflags});
        run_op(lat);
        e = sb.pop_front();
        n_chk++; if (result !== e.res) $display("FAIL fwd_sub_result got %h exp %h", result, e.res); else n_pass++;
        n_chk++; if (flags !== e.fl) $display("FAIL fwd_sub_flags got %b exp %b", flags, e.fl); else n_pass++;
        tick();
        // Immediate path: bus 1 as A, imm ORR; shifter bypassed so C stays as it was.
        idle_inputs();
        fwd_data = {32'h0000_1000, 32'd5};
        sel_a = 2'd2; use_imm = 1; imm = 32'h40; shift_imm = 8'd4; alu_op = 4'd5; set_flags = 1;
        sb.push_back('{res: 32'h1040, addr: 32'h1040, fl: mflags});
        run_op(lat);
        e = sb.pop_front();
        n_chk++; if (result !== e.res) $display("FAIL fwd_imm_result got %h exp %h", result, e.res); else n_pass++;
        n_chk++; if (flags !== e.fl) $display("FAIL fwd_imm_flags got %b exp %b", flags, e.fl); else n_pass++;
        tick();
    endtask

    task automatic test_shifter;
        logic [1:0]  t_op[8]  = '{2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};
        logic [7:0]  t_amt[8] = '{8'd40, 8'd0, 8'd32, 8'd36, 8'd32, 8'd33, 8'd4, 8'd1};
        logic        t_reg[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_res[8] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 32'h1800_0000,
                                  32'h0, 32'h0, 32'h0000_0010, 32'h0000_0002};
        logic        t_c[8]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            rf_b = 32'h8000_0001; alu_op = 4'd7; set_flags = 1;
            shift_op = t_op[i]; shift_by_reg = t_reg[i];
            if (t_reg[i]) rf_s = {24'd0, t_amt[i]};
            else          shift_imm = t_amt[i];
            mflags = {t_res[i][31], t_res[i] == 32'd0, t_c[i], mflags[0]};
            sb.push_back('{res: t_res[i], addr: t_res[i], fl: mflags});
            run_op(lat);
            e = sb.pop_front();
            n_chk++; if (result !== e.res) $display("FAIL shift%0d_result got %h exp %h", i, result, e.res); else n_pass++;
            n_chk++; if (flags !== e.fl) $display("FAIL shift%0d_flags got %b exp %b", i, flags, e.fl); else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure;
        idle_inputs();
        rf_a = 32'd1; rf_b = 32'd2; alu_op = 4'd0; out_ready = 0;
        sb.push_back('{res: 32'd3, addr: 32'd3, fl: mflags});
        run_op(lat);
        n_chk++; if (lat != 2) $display("FAIL bp_first_latency got %0d exp 2", lat); else n_pass++;
        rf_a = 32'd10; rf_b = 32'd20; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %b exp 0", i, in_ready); else n_pass++;
            n_chk++; if (result !== 32'd3 || out_valid !== 1'b1)
                $display("FAIL bp_hold%0d got %h/%b exp 00000003/1", i, result, out_valid); else n_pass++;
            tick();
        end
        out_ready = 1;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b exp 1", in_ready); else n_pass++;
        e = sb.pop_front();
        n_chk++; if (result !== e.res) $display("FAIL bp_first_result got %h exp %h", result, e.res); else n_pass++;
        sb.push_back('{res: 32'd30, addr: 32'd30, fl: mflags});
        tick();
        in_valid = 0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        n_chk++; if (lat != 2) $display("FAIL bp_second_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (result !== e.res) $display("FAIL bp_second_result got %h exp %h", result, e.res); else n_pass++;
        tick();
    endtask

    task automatic test_flush;
        logic seen;
        idle_inputs();
        rf_a = 32'd3; rf_b = 32'd4; alu_op = 4'd9; set_flags = 1;
        in_valid = 1;
        tick();
        in_valid = 0;
`ifdef EXEC_MUL_EN
        tick();
`endif
        flush = 1; in_valid = 1;
        #1;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else n_pass++;
        tick();
        flush = 0; in_valid = 0;
        n_chk++; if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy); else n_pass++;
        seen = out_valid;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", seen); else n_pass++;
        n_chk++; if (flags !== mflags) $display("FAIL flush_flags got %b exp %b", flags, mflags); else n_pass++;
        idle_inputs();
        rf_a = 32'h100; rf_b = 32'd8; alu_op = 4'd0; post_index = 1;
        sb.push_back('{res: 32'h108, addr: 32'h100, fl: mflags});
        run_op(lat);
        e = sb.pop_front();
        n_chk++; if (result !== e.res) $display("FAIL post_index_result got %h exp %h", result, e.res); else n_pass++;
        n_chk++; if (addr_out !== e.addr) $display("FAIL post_index_addr got %h exp %h", addr_out, e.addr); else n_pass++;
        tick();
    endtask

    task automatic test_mul;
        int exp_lat;
        idle_inputs();
        rf_a = 32'h0000_FFFF; rf_b = 32'h0001_0001; alu_op = 4'd9; set_flags = 1;
`ifdef EXEC_MUL_EN
        exp_lat = 33;
        mflags  = {2'b10, mflags[1:0]};
        sb.push_back('{res: 32'hFFFF_FFFF, addr: 32'hFFFF_FFFF, fl: mflags});
`else
        exp_lat = 2;
        sb.push_back('{res: 32'd0, addr: 32'd0, fl: mflags});
`endif
        run_op(lat);
        e = sb.pop_front();
        n_chk++; if (lat != exp_lat) $display("FAIL mul_latency got %0d exp %0d", lat, exp_lat); else n_pass++;
        n_chk++; if (result !== e.res) $display("FAIL mul_result got %h exp %h", result, e.res); else n_pass++;
        n_chk++; if (flags !== e.fl) $display("FAIL mul_flags got %b exp %b", flags, e.fl); else n_pass++;
        tick();
    endtask

    task automatic rand_op;
        logic [3:0] ops[7] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        rf_a      = $urandom;
        rf_b      = $urandom;
        alu_op    = ops[$urandom_range(0, 6)];
        shift_imm = 8'($urandom_range(0, 31));
        set_flags = 1'($urandom_range(0, 1));
    endtask

    task automatic test_back_to_back;
        int          sent, cyc;
        logic        acc;
        logic [35:0] m;
        idle_inputs();
        sent = 0; cyc = 0;
        rand_op();
        in_valid = 1;
        while ((sent < 12 || sb.size() > 0) && cyc < 200) begin
            #1;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL b2b_unexpected_output got result %h exp none", result);
                end else begin
                    e = sb.pop_front();
                    n_chk++; if (result !== e.res) $display("FAIL b2b_result got %h exp %h", result, e.res); else n_pass++;
                    n_chk++; if (flags !== e.fl) $display("FAIL b2b_flags got %b exp %b", flags, e.fl); else n_pass++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                m = model(alu_op, rf_a, rf_b, int'(shift_imm), mflags);
                if (set_flags) mflags = m[35:32];
                sb.push_back('{res: m[31:0], addr: m[31:0], fl: mflags});
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent < 12) rand_op();
                else           in_valid = 0;
            end
        end
        n_chk++; if (cyc >= 200 || sb.size() != 0)
            $display("FAIL b2b_drain got cycles %0d pending %0d exp <200/0", cyc, sb.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        idle_inputs();
        rf_a = 32'd5; rf_b = 32'd6; alu_op = 4'd9; set_flags = 1;
        in_valid = 1;
        tick();
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_chk++; if (result !== 32'd0 || addr_out !== 32'd0)
            $display("FAIL midrst_result got %h/%h exp 0/0", result, addr_out); else n_pass++;
        n_chk++; if (flags !== 4'd0) $display("FAIL midrst_flags got %b exp 0000", flags); else n_pass++;
        tick();
        rst_n = 1;
        mflags = 4'd0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_fwd_sub();
        test_shifter();
        test_backpressure();
        test_flush();
        test_mul();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
